// File: rtl/axil_sram_pkg.sv
// ============================================================================
//  Module      : axil_pkg
//  Description : Shared response codes and FSM state encodings for the
//                AXI4-Lite SRAM slave.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_WAIT = 2'd2,
        W_RESP = 2'd3
    } wr_state_e;

endpackage

`default_nettype wire

// File: rtl/axil_sram_if.sv
// ============================================================================
//  Module      : axil_sram_if
//  Description : AXI4-Lite bus bundle (AR, R, AW, W, B channels) with
//                master and slave views.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface axil_sram_if;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

endinterface

`default_nettype wire

// File: rtl/axil_sram_delay.sv
// ============================================================================
//  Module      : axil_sram_delay
//  Description : Wait-cycle counter for one channel. Loaded at the address
//                handshake, counts down to zero; o_done is high at zero.
//                With AXIL_SRAM_RAND_DELAY_EN defined, the load value is
//                LAT plus the low 3 bits of a free-running 16-bit Galois
//                LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module axil_sram_delay #(
    parameter int LAT = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_load,
    output logic      o_done
);

    // LAT up to 15 plus up to 7 random cycles fits in 5 bits
    localparam int c_CNT_W = 5;

    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_load_val;

`ifdef AXIL_SRAM_RAND_DELAY_EN
    logic [15:0] r_lfsr;

    // Right-shifting Galois LFSR, advances every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign w_load_val = c_CNT_W'(LAT) + c_CNT_W'(r_lfsr[2:0]);
`else
    assign w_load_val = c_CNT_W'(LAT);
`endif

    // Load on handshake, otherwise count down and hold at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= w_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/axil_sram.sv
// ============================================================================
//  Module      : axil_sram
//  Description : AXI4-Lite slave backed by a 2^DEPTH_LOG2 x 32-bit SRAM with
//                byte-lane writes and a configurable response latency.
//                Independent read and write FSMs. Out-of-window accesses
//                return DECERR. Optional macro AXIL_SRAM_RAND_DELAY_EN adds
//                0..7 pseudo-random wait cycles per transaction.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module axil_sram
    import axil_pkg::*;
#(
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LAT        = 2
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    axil_sram_if.slave bus
);

    localparam int c_NUM_WORDS = 1 << DEPTH_LOG2;

    logic [31:0] r_mem [c_NUM_WORDS];

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_e               r_rd_state;
    rd_state_e               w_rd_next;
    logic [31:0]             r_araddr;
    logic [31:0]             r_rdata;
    logic [1:0]              r_rresp;
    logic                    w_rd_load;
    logic                    w_rd_done;
    logic                    w_rd_sample;
    logic [31:0]             w_rd_off;
    logic                    w_rd_in_range;
    logic [DEPTH_LOG2-1:0]   w_rd_idx;

    // Offset wraps for addresses below BASE, so one unsigned test covers both ends
    assign w_rd_off      = r_araddr - BASE;
    assign w_rd_in_range = (w_rd_off >> (DEPTH_LOG2 + 2)) == 32'd0;
    assign w_rd_idx      = w_rd_off[DEPTH_LOG2+1:2];

    axil_sram_delay #(.LAT(LAT)) u_rd_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_rd_load),
        .o_done (w_rd_done)
    );

    // Read FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_state <= R_IDLE;
        end else begin
            r_rd_state <= w_rd_next;
        end
    end

    // Read FSM next state and handshake outputs
    always_comb begin
        w_rd_next   = r_rd_state;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        w_rd_load   = 1'b0;
        w_rd_sample = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                bus.arready = 1'b1;
                if (bus.arvalid) begin
                    w_rd_load = 1'b1;
                    w_rd_next = R_WAIT;
                end
            end
            R_WAIT: begin
                if (w_rd_done) begin
                    w_rd_sample = 1'b1;
                    w_rd_next   = R_RESP;
                end
            end
            R_RESP: begin
                bus.rvalid = 1'b1;
                if (bus.rready) begin
                    w_rd_next = R_IDLE;
                end
            end
            default: w_rd_next = R_IDLE;
        endcase
    end

    // Capture the read address on AR handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_araddr <= '0;
        end else if (w_rd_load) begin
            r_araddr <= bus.araddr;
        end
    end

    // Register read data once; it stays stable through R_RESP. A write to
    // the same word in this cycle lands after the sample, so old data wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_rd_sample) begin
            if (w_rd_in_range) begin
                r_rdata <= r_mem[w_rd_idx];
                r_rresp <= RESP_OKAY;
            end else begin
                r_rdata <= '0;
                r_rresp <= RESP_DECERR;
            end
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.rresp = r_rresp;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_e               r_wr_state;
    wr_state_e               w_wr_next;
    logic [31:0]             r_awaddr;
    logic [31:0]             r_wdata;
    logic [3:0]              r_wstrb;
    logic                    r_w_held;
    logic [1:0]              r_bresp;
    logic                    w_wr_load;
    logic                    w_wr_done;
    logic                    w_wr_commit;
    logic                    w_cap_aw;
    logic                    w_cap_w;
    logic [31:0]             w_wr_off;
    logic                    w_wr_in_range;
    logic [DEPTH_LOG2-1:0]   w_wr_idx;

    assign w_wr_off      = r_awaddr - BASE;
    assign w_wr_in_range = (w_wr_off >> (DEPTH_LOG2 + 2)) == 32'd0;
    assign w_wr_idx      = w_wr_off[DEPTH_LOG2+1:2];

    axil_sram_delay #(.LAT(LAT)) u_wr_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_wr_load),
        .o_done (w_wr_done)
    );

    // Write FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_state <= W_IDLE;
        end else begin
            r_wr_state <= w_wr_next;
        end
    end

    // Write FSM next state and handshake outputs. A W that arrives alone is
    // parked in W_IDLE (r_w_held) with wready dropped while awready stays high.
    always_comb begin
        w_wr_next   = r_wr_state;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        w_wr_load   = 1'b0;
        w_wr_commit = 1'b0;
        w_cap_aw    = 1'b0;
        w_cap_w     = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                bus.awready = 1'b1;
                bus.wready  = !r_w_held;
                w_cap_aw    = bus.awvalid;
                w_cap_w     = bus.wvalid && !r_w_held;
                if (bus.awvalid && (bus.wvalid || r_w_held)) begin
                    w_wr_load = 1'b1;
                    w_wr_next = W_WAIT;
                end else if (bus.awvalid) begin
                    w_wr_next = W_DATA;
                end
            end
            W_DATA: begin
                bus.wready = 1'b1;
                w_cap_w    = bus.wvalid;
                if (bus.wvalid) begin
                    w_wr_load = 1'b1;
                    w_wr_next = W_WAIT;
                end
            end
            W_WAIT: begin
                if (w_wr_done) begin
                    w_wr_commit = 1'b1;
                    w_wr_next   = W_RESP;
                end
            end
            W_RESP: begin
                bus.bvalid = 1'b1;
                if (bus.bready) begin
                    w_wr_next = W_IDLE;
                end
            end
            default: w_wr_next = W_IDLE;
        endcase
    end

    // Latch AW and W payloads independently; track an early-arriving W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_w_held <= 1'b0;
        end else begin
            if (w_cap_aw) begin
                r_awaddr <= bus.awaddr;
            end
            if (w_cap_w) begin
                r_wdata <= bus.wdata;
                r_wstrb <= bus.wstrb;
            end
            if (w_wr_load) begin
                r_w_held <= 1'b0;
            end else if (w_cap_w) begin
                r_w_held <= 1'b1;
            end
        end
    end

    // Write response decided at commit and held through W_RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bresp <= RESP_OKAY;
        end else if (w_wr_commit) begin
            r_bresp <= w_wr_in_range ? RESP_OKAY : RESP_DECERR;
        end
    end

    assign bus.bresp = r_bresp;

    // Array write with byte-lane enables; contents survive reset
    always_ff @(posedge clk) begin
        if (w_wr_commit && w_wr_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wstrb[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/axil_sram.md
AXIL_SRAM -- requirements
Module: axil_sram

Interface
REQ-001 SHALL have parameter BASE, default 32'h8000_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_LOG2, default 12, log2 of the number of 32-bit words.
REQ-003 SHALL have parameter LAT, default 2, wait cycles between handshake and response, range 0..15.
REQ-004 SHALL have one clock; reset SHALL be asynchronous and active-low; ports are listed below, clock and reset first.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 araddr/arvalid/arready  in/in/out  32/1/1  read-address channel.
REQ-008 rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read-data channel.
REQ-009 awaddr/awvalid/awready  in/in/out  32/1/1  write-address channel.
REQ-010 wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write-data channel.
REQ-011 bresp/bvalid/bready  out/out/in  2/1/1  write-response channel.

Function
REQ-012 Read FSM SHALL have three states: R_IDLE, R_WAIT and R_RESP.
REQ-013 In R_IDLE, arready SHALL be 1; arvalid&arready SHALL latch araddr, load the latency counter with LAT, and go to R_WAIT.
REQ-014 In R_WAIT, the counter SHALL decrement each cycle; at 0, rdata/rresp SHALL be registered and the FSM SHALL go to R_RESP. With LAT=0, R_WAIT lasts exactly one cycle.
REQ-015 In R_RESP, rvalid SHALL be 1 and rdata/rresp SHALL be stable until rready; rvalid&rready SHALL return the FSM to R_IDLE. No new AR is accepted in the same cycle.
REQ-016 Write FSM SHALL have four states: W_IDLE, W_DATA, W_WAIT and W_RESP.
- awready and wready are 1 in W_IDLE; AW and W are latched independently, in either order or together.
- When AW only has arrived, the FSM waits in W_DATA with wready high.
- When W only has arrived, the FSM SHALL wait with awready high.
REQ-017 Once both AW and W are held, the FSM SHALL spend LAT+1 cycles in W_WAIT. The array write SHALL occur on the exit cycle, byte lanes gated by wstrb. The FSM then goes to W_RESP with bvalid=1 until bready.
REQ-018 Word index SHALL be (addr-BASE)[DEPTH_LOG2+1:2]; addr[1:0] SHALL be ignored.
REQ-019 An address outside [BASE, BASE+4*2^DEPTH_LOG2) SHALL give resp=2'b11 (DECERR) with rdata=0 and no array write; otherwise resp SHALL be 2'b00.
REQ-020 Read and write channels SHALL operate concurrently. When the read sample and the array write hit the same word in the same cycle, the read SHALL return the old data.
REQ-021 wstrb=4'b0000 SHALL complete with OKAY and leave the array unchanged.

Reset
REQ-022 Reset SHALL force both FSMs to idle and clear the counters.
REQ-023 After reset, arready=awready=wready=1, rvalid=bvalid=0, rdata=0, rresp=bresp=0.
REQ-024 Reset asserted mid-transaction SHALL drop the transaction with no response; any array write not yet committed SHALL be lost.
REQ-025 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-026 Macro AXIL_SRAM_RAND_DELAY_EN SHALL select the wait-cycle source.
- Defined: each transaction's wait count is LAT plus the low 3 bits of a 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, reset seed 16'hACE1). The LFSR advances every cycle.
- Undefined: wait count is exactly LAT and no LFSR logic exists.

Structure
REQ-027 Package axil_pkg SHALL hold resp codes (RESP_OKAY, RESP_DECERR) and the read/write FSM state enums.
REQ-028 Sub-module axil_sram_delay SHALL hold the counter and the optional LFSR; it is instantiated once per channel.
REQ-029 The array SHALL be a single reg array of 2^DEPTH_LOG2 x 32 bits with a 4-byte-lane write enable.

Verification
REQ-030 Basic write then read: LAT=2, write 32'hDEADBEEF to 32'h8000_0010 with wstrb=4'hF, then read it. bvalid SHALL rise 3 cycles after AW+W; rdata SHALL be 32'hDEADBEEF with rresp=0.
REQ-031 Partial write: wstrb=4'b0010 with wdata=32'h0000_5500 over 32'hDEADBEEF. A read SHALL return 32'hDEAD55EF.
REQ-032 Out-of-range access: read from 32'h7FFF_FFFC SHALL give rresp=2'b11 and rdata=0. A write to BASE+4*4096 SHALL give bresp=2'b11 and no array change.
REQ-033 Channel ordering and backpressure: W sent 5 cycles before AW SHALL complete correctly. Holding bready=0 for 4 cycles SHALL keep bvalid and bresp stable, with awready=0.
REQ-034 Reset mid-write: deassert rst_n during W_WAIT, release, then read the target word. The word SHALL hold its old value, and bvalid SHALL stay 0 throughout.
REQ-035 Random delay: with AXIL_SRAM_RAND_DELAY_EN defined and LAT=0, run 100 reads. Every latency SHALL be in 1..8 and all data SHALL be correct.
